lfu_repl_ctrl: RTL and testbench
================================

Name: lfu_repl_ctrl

Overview:
Parametrised Least-Frequently-Used replacement controller for an N-entry buffer pool.
- Keeps one saturating use counter per entry; periodic aging halves all counters so stale history decays.
- On a new-buffer request, returns the entry with the lowest count and reloads that entry's counter.
- Sits beside the buffer manager; the manager sends reference strobes and consumes the victim index.

Parameters:
NUM_ENT, 4, number of tracked entries (2..32; need not be a power of two)
CNT_W, 4, use-counter width in bits (2..8); max count = 2^CNT_W-1
IDX_W, $clog2(NUM_ENT), entry index width (derived; never overridden)
FF_DLY, 1, simulation delay on all register assignments

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous reset, active low
ref_vld  in  1  one entry is referenced this cycle
ref_idx  in  IDX_W  referenced entry; sampled only when ref_vld=1
new_buf_req  in  1  request for a replacement victim
repl_vld  out  1  one-cycle pulse: buf_num_replc is valid
buf_num_replc  out  IDX_W  victim entry index; holds its value between requests
age_pulse  out  1  one-cycle pulse, one cycle after an aging event

Behaviour:
- Reset (asynchronous, immediate, applies mid-operation): all cnt[i]=0, buf_num_replc=0, repl_vld=0, age_pulse=0.
- Victim select is combinational over the registered counts from before this cycle's update:
  - victim = index of minimum cnt.
  - Ties are won by the lowest index.
  - Indices >= NUM_ENT are never candidates.
- new_buf_req=1 at edge k:
  - buf_num_replc <= victim, repl_vld <= 1, visible after edge k (1-cycle latency).
  - cnt[victim] <= 1 (the newly loaded entry counts as one use).
- new_buf_req=0: repl_vld <= 0; buf_num_replc holds.
- Back-to-back requests are legal, one per cycle. Each request sees the counts updated by the previous one, so the same index is not returned twice in a row unless no other entry has a lower count.
- ref_vld=1, ref_idx < NUM_ENT, no aging: cnt[ref_idx] <= cnt[ref_idx]+1.
- Aging trigger: ref_vld=1 and cnt[ref_idx] equals the maximum count.
  - Every counter is right-shifted by 1.
  - The referenced counter then gets +1: cnt[ref_idx] <= (max>>1)+1.
  - age_pulse <= 1 for one cycle.
  - Counters never wrap.
- ref_vld=1 with ref_idx >= NUM_ENT: ignored; no count change, no aging.
- ref_vld and new_buf_req in the same cycle:
  - The victim is chosen from the pre-update counts.
  - The reference applies to the other entries as normal, including an aging trigger (non-victim counters halve).
  - cnt[victim] <= 1 always; replacement wins even if ref_idx == victim and even if aging fires.
- There is no back-pressure. The requester must consume repl_vld in the pulse cycle.

Decomposition:
- Package lfu_pkg holds:
  - LFU_CNT_MAX(CNT_W) constant function
  - default parameter values
  - localparam for the counter reset/reload values (0 and 1)
- Sub-module lfu_argmin:
  - purely combinational, parametrised by NUM_ENT and CNT_W
  - input: flattened counter vector; output: minimum index with lowest-index tie-break
  - built as a log2 compare tree, so it is reusable by the future LRU/LFU hybrid
- lfu_repl_ctrl holds the counter array, the update/aging logic and the output registers.

Test Plan:
1. NUM_ENT=4, CNT_W=4. Reset, then new_buf_req one cycle → repl_vld=1 next cycle, buf_num_replc=0, cnt={1,0,0,0}. A second request → buf_num_replc=1.
2. Refs 0,0,1,2 then new_buf_req → counts {2,1,1,0}, buf_num_replc=3; afterwards cnt[3]=1.
3. CNT_W=2. Ref 0 ×3 (cnt0=3), ref 1 once, ref 0 again:
   - Aging gives {2,0,0,0} and age_pulse=1 one cycle later.
   - new_buf_req → buf_num_replc=1 (tie broken by lowest index).
4. Counts {2,0,1,1}; same cycle ref_vld=1, ref_idx=1, new_buf_req=1 → buf_num_replc=1; cnt={2,1,1,1}.
5. NUM_ENT=5, counts all 1: ref_idx=6 with ref_vld=1 → no change. new_buf_req → victim 0, never 5..7.
6. Drop rst_n between clock edges while repl_vld=1 and buf_num_replc=2 → both outputs 0 immediately (before the next edge); counters 0; first post-reset request returns 0.

Source files
------------

// File: rtl/lfu_pkg.sv
// Shared constants and helpers for the LFU replacement controller family.
package lfu_pkg;

  localparam int LFU_NUM_ENT_DEF = 4;
  localparam int LFU_CNT_W_DEF   = 4;
  localparam int LFU_FF_DLY_DEF  = 1;

  // Counter value after reset, and the value a freshly loaded entry starts at.
  localparam int LFU_CNT_RST  = 0;
  localparam int LFU_CNT_LOAD = 1;

  // Saturation point of a CNT_W-bit use counter.
  function automatic int LFU_CNT_MAX(input int cnt_w);
    return (1 << cnt_w) - 1;
  endfunction

endpackage

// File: rtl/lfu_argmin.sv
// Combinational arg-min over NUM_ENT packed counters. Binary compare tree,
// padded to a power of two; padding leaves are invalid and never win.
// Ties go to the left (lower-index) subtree.
module lfu_argmin #(
  parameter int NUM_ENT = 4,
  parameter int CNT_W   = 4,
  parameter int IDX_W   = $clog2(NUM_ENT)
) (
  input  logic [NUM_ENT*CNT_W-1:0] cnt_flat,
  output logic [IDX_W-1:0]         min_idx
);

  localparam int LVLS = $clog2(NUM_ENT);
  localparam int P    = 1 << LVLS;

  // Heap-ordered tree: node i has children 2i and 2i+1, leaves at P..2P-1.
  logic [CNT_W-1:0] n_val [1:2*P-1];
  logic [IDX_W-1:0] n_idx [1:2*P-1];
  logic [2*P-1:2]   n_vld;

  for (genvar j = 0; j < P; j++) begin : g_leaf
    if (j < NUM_ENT) begin : g_real
      assign n_val[P+j] = cnt_flat[j*CNT_W +: CNT_W];
      assign n_vld[P+j] = 1'b1;
    end else begin : g_pad
      assign n_val[P+j] = '0;
      assign n_vld[P+j] = 1'b0;
    end
    assign n_idx[P+j] = IDX_W'(j);
  end

  for (genvar i = 1; i < P; i++) begin : g_node
    logic take_r;
    // Right child wins only when strictly smaller, keeping the lowest index on ties.
    assign take_r   = n_vld[2*i+1] && (!n_vld[2*i] || (n_val[2*i+1] < n_val[2*i]));
    assign n_val[i] = take_r ? n_val[2*i+1] : n_val[2*i];
    assign n_idx[i] = take_r ? n_idx[2*i+1] : n_idx[2*i];
    if (i > 1) begin : g_vld
      assign n_vld[i] = n_vld[2*i] | n_vld[2*i+1];
    end
  end

  assign min_idx = n_idx[1];

endmodule

// File: rtl/lfu_repl_ctrl.sv
// LFU replacement controller: per-entry saturating use counters with
// halving on saturation, victim = least-used entry, reloaded on replacement.
module lfu_repl_ctrl
  import lfu_pkg::*;
#(
  parameter int NUM_ENT = LFU_NUM_ENT_DEF,
  parameter int CNT_W   = LFU_CNT_W_DEF,
  parameter int IDX_W   = $clog2(NUM_ENT),
  parameter int FF_DLY  = LFU_FF_DLY_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ref_vld,
  input  logic [IDX_W-1:0] ref_idx,
  input  logic             new_buf_req,
  output logic             repl_vld,
  output logic [IDX_W-1:0] buf_num_replc,
  output logic             age_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(LFU_CNT_MAX(CNT_W));
  localparam logic [CNT_W-1:0] CNT_AGE_REF = (CNT_MAX >> 1) + CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_RST     = CNT_W'(LFU_CNT_RST);
  localparam logic [CNT_W-1:0] CNT_LOAD    = CNT_W'(LFU_CNT_LOAD);

  // FF_DLY is accepted for drop-in compatibility with delay-annotated
  // siblings; this RTL carries no delays. Reject nonsensical overrides early.
  if (FF_DLY < 0 || IDX_W != $clog2(NUM_ENT) || NUM_ENT < 2 || NUM_ENT > 32) begin : g_bad_param
    $error("lfu_repl_ctrl: illegal parameter combination");
  end

  logic [CNT_W-1:0]         cnt_q [NUM_ENT];
  logic [CNT_W-1:0]         cnt_d [NUM_ENT];
  logic [NUM_ENT*CNT_W-1:0] cnt_flat;
  logic [IDX_W-1:0]         victim;
  logic                     age_hit;

  // Pack the registered counts for the arg-min tree.
  always_comb begin
    cnt_flat = '0;
    for (int i = 0; i < NUM_ENT; i++) begin
      cnt_flat[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  lfu_argmin #(
    .NUM_ENT (NUM_ENT),
    .CNT_W   (CNT_W),
    .IDX_W   (IDX_W)
  ) u_argmin (
    .cnt_flat (cnt_flat),
    .min_idx  (victim)
  );

  // Aging fires when a valid reference hits a saturated counter; out-of-range
  // indices never match any entry, so they are ignored here and below.
  always_comb begin
    age_hit = 1'b0;
    for (int i = 0; i < NUM_ENT; i++) begin
      if (ref_vld && (ref_idx == IDX_W'(i)) && (cnt_q[i] == CNT_MAX)) begin
        age_hit = 1'b1;
      end
    end
  end

  // Next counts: halve on aging, then apply the reference, then let the
  // replacement reload override whatever happened to the victim.
  always_comb begin
    for (int i = 0; i < NUM_ENT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (age_hit) begin
        cnt_d[i] = cnt_q[i] >> 1;
      end
      if (ref_vld && (ref_idx == IDX_W'(i))) begin
        cnt_d[i] = age_hit ? CNT_AGE_REF : cnt_q[i] + CNT_W'(1);
      end
      if (new_buf_req && (victim == IDX_W'(i))) begin
        cnt_d[i] = CNT_LOAD;
      end
    end
  end

  // Counter array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENT; i++) begin
        cnt_q[i] <= CNT_RST;
      end
    end else begin
      for (int i = 0; i < NUM_ENT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  // Output registers: victim pulse with held index, and the aging strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      repl_vld      <= 1'b0;
      buf_num_replc <= '0;
      age_pulse     <= 1'b0;
    end else begin
      repl_vld  <= new_buf_req;
      age_pulse <= age_hit;
      if (new_buf_req) begin
        buf_num_replc <= victim;
      end
    end
  end

endmodule

// File: tb/tb_lfu_repl_ctrl.sv
// Scoreboard bench for lfu_repl_ctrl: a behavioural LFU model predicts each
// victim and aging event; a monitor matches them against DUT output pulses.
module tb_lfu_repl_ctrl;

  localparam int NUM_ENT = 5;
  localparam int CNT_W   = 2;
  localparam int IDX_W   = $clog2(NUM_ENT);
  localparam int MAXC    = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             ref_vld = 1'b0;
  logic [IDX_W-1:0] ref_idx = '0;
  logic             new_buf_req = 1'b0;
  logic             repl_vld;
  logic [IDX_W-1:0] buf_num_replc;
  logic             age_pulse;

  lfu_repl_ctrl #(
    .NUM_ENT (NUM_ENT),
    .CNT_W   (CNT_W),
    .FF_DLY  (1)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ref_vld       (ref_vld),
    .ref_idx       (ref_idx),
    .new_buf_req   (new_buf_req),
    .repl_vld      (repl_vld),
    .buf_num_replc (buf_num_replc),
    .age_pulse     (age_pulse)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int cyc;
  } exp_t;

  exp_t exp_repl[$];
  int   exp_age[$];
  int   m_cnt [NUM_ENT];
  int   m_last = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Reference model: least-used entry wins (lowest index on ties); a reference
  // to a saturated counter halves everyone and lands the referenced entry just
  // above half; replacement always reloads the victim to one use.
  task automatic model_step(input bit req, input bit rv, input int ridx);
    int  v;
    bit  aging;
    v = 0;
    for (int i = 1; i < NUM_ENT; i++) if (m_cnt[i] < m_cnt[v]) v = i;
    aging = 1'b0;
    if (rv && ridx < NUM_ENT) begin
      if (m_cnt[ridx] == MAXC) aging = 1'b1;
    end
    if (req) exp_repl.push_back('{idx: v, cyc: cyc + 1});
    if (aging) begin
      for (int i = 0; i < NUM_ENT; i++) m_cnt[i] = m_cnt[i] / 2;
      m_cnt[ridx] = MAXC / 2 + 1;
      exp_age.push_back(cyc + 1);
    end else if (rv && ridx < NUM_ENT) begin
      m_cnt[ridx] = m_cnt[ridx] + 1;
    end
    if (req) m_cnt[v] = 1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_ENT; i++) m_cnt[i] = 0;
    m_last = 0;
    exp_repl.delete();
    exp_age.delete();
  endtask

  task automatic step(input bit req, input bit rv, input int ridx);
    @(negedge clk);
    new_buf_req = req;
    ref_vld     = rv;
    ref_idx     = ridx[IDX_W-1:0];
    model_step(req, rv, ridx);
  endtask

  // Asynchronous reset dropped between edges, right after the pending
  // outputs of the last step became visible.
  task automatic mid_reset();
    @(posedge clk);
    #3;
    rst_n       = 1'b0;
    new_buf_req = 1'b0;
    ref_vld     = 1'b0;
    ref_idx     = '0;
    #1;
    chk("rst_repl_vld", int'(repl_vld), 0);
    chk("rst_buf_num", int'(buf_num_replc), 0);
    chk("rst_age_pulse", int'(age_pulse), 0);
    chk("rst_repl_q_drained", exp_repl.size(), 0);
    chk("rst_age_q_drained", exp_age.size(), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: consume expectations whenever the DUT pulses; flag late/missing ones.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (repl_vld) begin
        chk("repl_expected", int'(exp_repl.size() > 0), 1);
        if (exp_repl.size() > 0) begin
          e = exp_repl.pop_front();
          chk("repl_idx", int'(buf_num_replc), e.idx);
          chk("repl_cycle", cyc, e.cyc);
          m_last = e.idx;
        end
      end else begin
        chk("repl_hold", int'(buf_num_replc), m_last);
      end
      if (exp_repl.size() > 0 && exp_repl[0].cyc <= cyc) begin
        chk("repl_missing_at_cycle", cyc, exp_repl[0].cyc - 1);
        void'(exp_repl.pop_front());
      end
      if (age_pulse) begin
        chk("age_expected", int'(exp_age.size() > 0), 1);
        if (exp_age.size() > 0) chk("age_cycle", cyc, exp_age.pop_front());
      end
      if (exp_age.size() > 0 && exp_age[0] <= cyc) begin
        chk("age_missing_at_cycle", cyc, exp_age[0] - 1);
        void'(exp_age.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #12;
    chk("init_repl_vld", int'(repl_vld), 0);
    chk("init_buf_num", int'(buf_num_replc), 0);
    chk("init_age_pulse", int'(age_pulse), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // First requests after reset: entry 0, then entry 1.
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    mid_reset();

    // Refs 0,0,1,2 then a request: entry 3 is the least used.
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 1); step(0, 1, 2);
    step(1, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    mid_reset();

    // Saturate entry 0, reference 1, then hit 0 again to trigger aging.
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 0);
    step(0, 1, 1);
    step(0, 1, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    step(0, 0, 0);
    mid_reset();

    // Reference and request together on the victim: replacement wins.
    step(0, 1, 0); step(0, 1, 0); step(0, 1, 2); step(0, 1, 3);
    step(1, 1, 1);
    step(1, 0, 0);
    step(0, 0, 0);
    mid_reset();

    // Load every entry once, poke out-of-range indices, then request.
    for (int i = 0; i < NUM_ENT; i++) step(1, 0, 0);
    step(0, 1, 6); step(0, 1, 5); step(0, 1, 7);
    step(1, 0, 0);
    step(0, 0, 0);
    mid_reset();

    // Reset while a replacement of entry 2 is being presented.
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    mid_reset();
    step(1, 0, 0);
    step(0, 0, 0);

    // Randomized traffic, with aging forced on by heavy referencing.
    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0,
           int'($urandom_range(0, (1 << IDX_W) - 1)));
    end
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    @(posedge clk);
    #2;
    chk("end_repl_q_drained", exp_repl.size(), 0);
    chk("end_age_q_drained", exp_age.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
